pll_lock_detect: RTL and testbench



---
 rtl/pll_lock_detect_pkg.sv | 31 +++
 rtl/pll_lock_detect_meter.sv | 43 ++++
 rtl/pll_lock_detect.sv | 111 +++++++++++
 tb/tb_pll_lock_detect.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_detect_pkg.sv
// Shared constants and helpers for the PLL lock detector and its period meters.
// The PLL core and the display path use the same period width and defaults.
package pll_lock_detect_pkg;

    localparam int unsigned PERIOD_W = 16;

    typedef logic [PERIOD_W-1:0] period_t;

    localparam period_t     PERIOD_SAT     = '1;
    localparam int unsigned DEF_TOL        = 4;
    localparam int unsigned DEF_LOCK_COUNT = 8;
    localparam period_t     DEF_TIMEOUT    = 16'd65000;

    typedef enum logic [1:0] {
        CMP_NONE,
        CMP_GOOD,
        CMP_BAD
    } cmp_t;

    function automatic period_t sat_inc(input period_t v);
        return (v == PERIOD_SAT) ? PERIOD_SAT : v + 1'b1;
    endfunction

    // Magnitude of a 17-bit signed difference of two periods.
    function automatic logic [PERIOD_W:0] abs_diff(input period_t a, input period_t b);
        logic signed [PERIOD_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return d[PERIOD_W] ? $unsigned(-d) : $unsigned(d);
    endfunction

endpackage

// File: rtl/pll_lock_detect_meter.sv
// Edge-to-edge period meter: counts clk_50 cycles between rising edges of `in`.
// The first rising edge after reset only arms the meter.
module edge_period_meter
    import pll_lock_detect_pkg::*;
(
    input  logic                clk_50,
    input  logic                rst,
    input  logic                in,
    output logic [PERIOD_W-1:0] period,
    output logic                valid,
    output logic [PERIOD_W-1:0] cnt
);

    logic r_prev;
    logic r_armed;
    logic w_edge;

    assign w_edge = in & ~r_prev;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_prev  <= 1'b1;   // a level already high at reset release is not an edge
            r_armed <= 1'b0;
            period  <= '0;
            valid   <= 1'b0;
            cnt     <= '0;
        end else begin
            r_prev <= in;
            valid  <= 1'b0;
            if (w_edge) begin
                if (r_armed) begin
                    period <= sat_inc(cnt);
                    valid  <= 1'b1;
                end
                cnt     <= '0;
                r_armed <= 1'b1;
            end else begin
                cnt <= sat_inc(cnt);
            end
        end
    end

endmodule

// File: rtl/pll_lock_detect.sv
// PLL lock detector: compares fb and vco periods on every fb measurement,
// counts consecutive good comparisons into `locked`, and flags loss of feedback.
module pll_lock_detect
    import pll_lock_detect_pkg::*;
#(
    parameter int unsigned TOL        = DEF_TOL,
    parameter int unsigned LOCK_COUNT = DEF_LOCK_COUNT,
    parameter logic [15:0] TIMEOUT    = DEF_TIMEOUT
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        vco,
    input  logic        fb,
    output logic [15:0] fb_period,
    output logic [15:0] vco_period,
    output logic        fb_valid,
    output logic [7:0]  good_ctr,
    output logic        locked,
    output logic        fb_lost
);

    localparam logic [7:0]        LOCK_CNT8 = 8'(LOCK_COUNT);
    localparam logic [PERIOD_W:0] TOL17     = 17'(TOL);

    logic          w_vco_valid;
    logic [15:0]   w_vco_cnt_unused;
    logic [15:0]   w_fb_cnt;
    logic          r_vco_seen;
    logic          r_fb_prev;
    logic          w_fb_edge;
    logic          w_timeout;
    logic          w_seen;
    logic [7:0]    w_good_next;
    cmp_t          w_cmp;

    edge_period_meter u_vco_meter (
        .clk_50 (clk_50),
        .rst    (rst),
        .in     (vco),
        .period (vco_period),
        .valid  (w_vco_valid),
        .cnt    (w_vco_cnt_unused)
    );

    edge_period_meter u_fb_meter (
        .clk_50 (clk_50),
        .rst    (rst),
        .in     (fb),
        .period (fb_period),
        .valid  (fb_valid),
        .cnt    (w_fb_cnt)
    );

    // Local copy of the fb edge so fb_lost clears in the same update as the meter's cnt.
    assign w_fb_edge = fb & ~r_fb_prev;
    assign w_timeout = (w_fb_cnt >= TIMEOUT);
    // A vco measurement landing in the same cycle as fb_valid already counts as seen.
    assign w_seen    = r_vco_seen | w_vco_valid;

    always_comb begin
        w_good_next = (good_ctr >= LOCK_CNT8) ? LOCK_CNT8 : good_ctr + 8'd1;
        w_cmp       = CMP_NONE;
        if (fb_valid) begin
            if (w_seen && (fb_period != PERIOD_SAT) && (vco_period != PERIOD_SAT) &&
                (abs_diff(fb_period, vco_period) <= TOL17)) begin
                w_cmp = CMP_GOOD;
            end else begin
                w_cmp = CMP_BAD;
            end
        end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            r_vco_seen <= 1'b0;
            r_fb_prev  <= 1'b1;
            good_ctr   <= '0;
            locked     <= 1'b0;
            fb_lost    <= 1'b0;
        end else begin
            r_fb_prev <= fb;
            if (w_vco_valid) begin
                r_vco_seen <= 1'b1;
            end

            if (w_fb_edge) begin
                fb_lost <= 1'b0;
            end else if (w_timeout) begin
                fb_lost <= 1'b1;
            end

            if (w_timeout) begin
                good_ctr <= '0;
                locked   <= 1'b0;
            end else begin
                case (w_cmp)
                    CMP_GOOD: begin
                        good_ctr <= w_good_next;
                        locked   <= (w_good_next == LOCK_CNT8);
                    end
                    CMP_BAD: begin
                        good_ctr <= '0;
                        locked   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_detect.sv
// Self-checking bench for pll_lock_detect: square-wave generators with random
// periods, checked every cycle against a timestamp-based reference model.
module tb_pll_lock_detect;

    localparam int TOL = 4;
    localparam int LC  = 8;
    localparam int TMO = 1000;
    localparam int SAT = 65535;

    logic        clk_50 = 1'b0;
    logic        rst    = 1'b1;
    logic        vco    = 1'b1;
    logic        fb     = 1'b1;
    logic [15:0] fb_period;
    logic [15:0] vco_period;
    logic        fb_valid;
    logic [7:0]  good_ctr;
    logic        locked;
    logic        fb_lost;

    pll_lock_detect #(
        .TOL        (TOL),
        .LOCK_COUNT (LC),
        .TIMEOUT    (16'(TMO))
    ) dut (
        .clk_50     (clk_50),
        .rst        (rst),
        .vco        (vco),
        .fb         (fb),
        .fb_period  (fb_period),
        .vco_period (vco_period),
        .fb_valid   (fb_valid),
        .good_ctr   (good_ctr),
        .locked     (locked),
        .fb_lost    (fb_lost)
    );

    always #10 clk_50 = ~clk_50;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: periods are differences of edge timestamps.
    int m_t, m_vprev, m_fprev, m_vlast, m_flast, m_fref;
    int m_vp, m_fp, m_vval, m_fval, m_seen, m_run, m_lost;

    // Stimulus generators: index 0 = vco, 1 = fb.
    int g_per[2], g_pos[2], g_lo[2], g_hi[2];
    bit g_hold[2];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_vprev = 1; m_fprev = 1; m_vlast = -1; m_flast = -1; m_fref = 0;
        m_vp = 0; m_fp = 0; m_vval = 0; m_fval = 0; m_seen = 0; m_run = 0; m_lost = 0;
    endtask

    task automatic model_step(input int v, input int f);
        int fcnt, d;
        bit ve, fe;
        fcnt = imin(m_t - m_fref, SAT);
        ve = (v != 0) && (m_vprev == 0);
        fe = (f != 0) && (m_fprev == 0);
        if (fcnt >= TMO) begin
            m_run = 0;
        end else if (m_fval != 0) begin
            d = m_fp - m_vp;
            if (d < 0) d = -d;
            if ((m_seen != 0 || m_vval != 0) && m_fp != SAT && m_vp != SAT && d <= TOL)
                m_run = imin(m_run + 1, 1000);
            else
                m_run = 0;
        end
        if (fe) m_lost = 0;
        else if (fcnt >= TMO) m_lost = 1;
        if (m_vval != 0) m_seen = 1;
        m_vval = 0;
        if (ve) begin
            if (m_vlast >= 0) begin m_vp = imin(m_t - m_vlast, SAT); m_vval = 1; end
            m_vlast = m_t;
        end
        m_fval = 0;
        if (fe) begin
            if (m_flast >= 0) begin m_fp = imin(m_t - m_flast, SAT); m_fval = 1; end
            m_flast = m_t;
            m_fref  = m_t + 1;
        end
        m_vprev = v; m_fprev = f; m_t++;
    endtask

    task automatic check_all();
        chk("fb_period",  fb_period,  16'(m_fp));
        chk("vco_period", vco_period, 16'(m_vp));
        chk("fb_valid",   16'(fb_valid), 16'(m_fval));
        chk("good_ctr",   16'(good_ctr), 16'(imin(m_run, LC)));
        chk("locked",     16'(locked),   16'(m_run >= LC));
        chk("fb_lost",    16'(fb_lost),  16'(m_lost));
    endtask

    function automatic int pick(input int i);
        return int'($urandom_range(g_hi[i], g_lo[i]));
    endfunction

    task automatic set_rng(input int i, input int lo, input int hi);
        g_lo[i] = lo; g_hi[i] = hi;
    endtask

    task automatic gen_reset();
        for (int i = 0; i < 2; i++) begin g_pos[i] = 0; g_per[i] = pick(i); end
    endtask

    function automatic logic level(input int i);
        return !g_hold[i] && (g_pos[i] < g_per[i] / 2);
    endfunction

    task automatic step();
        vco = level(0);
        fb  = level(1);
        @(posedge clk_50);
        model_step(int'(vco), int'(fb));
        for (int i = 0; i < 2; i++) begin
            if (g_hold[i]) begin
                g_pos[i] = 0;
                g_per[i] = pick(i);
            end else begin
                g_pos[i]++;
                if (g_pos[i] >= g_per[i]) begin g_pos[i] = 0; g_per[i] = pick(i); end
            end
        end
        @(negedge clk_50);
        check_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset_release();
        @(negedge clk_50);
        rst = 1'b0;
        model_reset();
        gen_reset();
    endtask

    initial begin
        int early;
        g_hold[0] = 1'b0; g_hold[1] = 1'b0;
        set_rng(0, 200, 200);
        set_rng(1, 200, 200);
        model_reset();
        repeat (2) @(negedge clk_50);
        check_all();

        // Both inputs high at release: first edges only arm.
        do_reset_release();
        early = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (fb_valid || dut.u_vco_meter.valid) early++;
        end
        chk("no_early_valid", 16'(early), 16'd0);
        run(200 * 8 + 10);
        chk("lock200_locked", 16'(locked), 16'd1);
        chk("lock200_fb", fb_period, 16'h00C8);
        chk("lock200_vco", vco_period, 16'h00C8);
        chk("lock200_good", 16'(good_ctr), 16'd8);

        // Tolerance boundary: diff 4 good, diff 5 bad.
        set_rng(1, 204, 204);
        run(204 * 10);
        chk("tol4_locked", 16'(locked), 16'd1);
        chk("tol4_fb", fb_period, 16'd204);
        set_rng(1, 205, 205);
        run(205 * 10);
        chk("tol5_locked", 16'(locked), 16'd0);
        chk("tol5_good", 16'(good_ctr), 16'd0);

        // Single long fb period breaks lock, then relock.
        set_rng(1, 200, 200);
        run(200 * 12);
        chk("relock_a", 16'(locked), 16'd1);
        set_rng(1, 300, 300);
        run(200);
        set_rng(1, 200, 200);
        run(310);
        chk("glitch_locked", 16'(locked), 16'd0);
        chk("glitch_good", 16'(good_ctr), 16'd0);
        run(200 * 10);
        chk("relock_b", 16'(locked), 16'd1);

        // Randomized periods around the tolerance window.
        set_rng(0, 198, 202);
        set_rng(1, 194, 208);
        run(200 * 40);
        set_rng(0, 200, 200);
        set_rng(1, 196, 204);
        run(200 * 10);

        // Feedback loss and recovery.
        set_rng(1, 200, 200);
        run(200 * 12);
        g_hold[1] = 1'b1;
        run(1100);
        chk("timeout_lost", 16'(fb_lost), 16'd1);
        chk("timeout_locked", 16'(locked), 16'd0);
        g_hold[1] = 1'b0;
        run(3);
        chk("timeout_clear", 16'(fb_lost), 16'd0);
        run(200 * 12);
        chk("relock_c", 16'(locked), 16'd1);

        // Asynchronous reset mid-count, then fb measured before any vco.
        run(77);
        #3 rst = 1'b1;
        #1;
        chk("arst_locked", 16'(locked), 16'd0);
        chk("arst_good", 16'(good_ctr), 16'd0);
        chk("arst_fbp", fb_period, 16'd0);
        chk("arst_vcop", vco_period, 16'd0);
        chk("arst_valid", 16'(fb_valid), 16'd0);
        chk("arst_lost", 16'(fb_lost), 16'd0);
        g_hold[0] = 1'b1;
        vco = 1'b0;
        repeat (2) @(negedge clk_50);
        do_reset_release();
        run(200 * 3 + 5);
        chk("noseen_good", 16'(good_ctr), 16'd0);
        chk("noseen_locked", 16'(locked), 16'd0);
        g_hold[0] = 1'b0;
        run(200 * 14);
        chk("relock_d", 16'(locked), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
